// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: prioritised, non-nesting interrupt controller for the 8-bit pipelined
// MIPS core.
//
// Request lines are rising-edge detected into a pending register. The pending register is
// gated by a software-writable enable mask. The lowest-indexed eligible source wins.
// The winner is presented to jump control as a single interrupt plus a vector. The controller
// then tracks the handler until its return has retired.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   irq_in      raw request lines, rising-edge sensitive, synchronous to clk
//   mask_wr     write strobe for the enable mask
//   mask_data   new mask value (1 = source enabled)
//   int_ack     one-cycle pulse: jump control has taken the redirect
//   int_ret     one-cycle pulse: return-from-interrupt has retired
//   interrupt   request to jump control (high only while requesting)
//   int_vector  jump target, VEC_BASE + 4*int_id modulo 256
//   int_id      index of the current or last-served source
//   in_service  high while a handler is executing
//   pending     latched, not-yet-acknowledged requests
module irq_priority_ctrl #(
    parameter int unsigned NUM_SRC  = 4,
    parameter logic [7:0]  VEC_BASE = 8'hE0,
    parameter int unsigned ID_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               interrupt,
    output logic [7:0]         int_vector,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         int_vector_q, int_vector_d;

    assign rise     = irq_in & ~irq_prev_q;
    // mask_q is the pre-write value, so a mask write only affects later decisions.
    assign eligible = pending_q & mask_q;

    // Scan from the top down so the lowest set index is the last assignment and wins.
    always_comb begin
        win_id = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        int_id_d     = int_id_q;
        int_vector_d = int_vector_q;
        clr          = '0;
        case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d      = StReq;
                    int_id_d     = win_id;
                    int_vector_d = VEC_BASE + (8'(win_id) << 2);
                end
            end
            StReq: begin
                // An ack takes precedence: once jump control has redirected, the handler runs.
                if (int_ack) begin
                    state_d       = StService;
                    clr[int_id_q] = 1'b1;
                end else if (!mask_q[int_id_q]) begin
                    // Withdrawal: the request stays pending for a later re-enable.
                    state_d = StIdle;
                end
            end
            StService: begin
                if (int_ret) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh edge landing in the ack cycle re-sets the bit (set wins over clear).
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            int_id_q     <= '0;
            int_vector_q <= VEC_BASE;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_in;
            pending_q    <= pending_d;
            int_id_q     <= int_id_d;
            int_vector_q <= int_vector_d;
            if (mask_wr) begin
                mask_q <= mask_data;
            end
        end
    end

    assign interrupt  = (state_q == StReq);
    assign in_service = (state_q == StService);
    assign int_id     = int_id_q;
    assign int_vector = int_vector_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       int_ack;
    logic       int_ret;

    logic       interrupt, in_service;
    logic [7:0] int_vector;
    logic [1:0] int_id;
    logic [3:0] pending;

    logic       interrupt2, in_service2;
    logic [7:0] int_vector2;
    logic [1:0] int_id2;
    logic [3:0] pending2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_priority_ctrl #(
        .NUM_SRC  (4),
        .VEC_BASE (8'hE0),
        .ID_W     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .interrupt  (interrupt),
        .int_vector (int_vector),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    // Same stimulus, base chosen so that id 1 wraps to vector 8'h00.
    irq_priority_ctrl #(
        .NUM_SRC  (4),
        .VEC_BASE (8'hFC),
        .ID_W     (2)
    ) dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .interrupt  (interrupt2),
        .int_vector (int_vector2),
        .int_id     (int_id2),
        .in_service (in_service2),
        .pending    (pending2)
    );

    typedef struct {
        logic [3:0] irq;
        logic       mw;
        logic [3:0] md;
        logic       ack;
        logic       ret;
        logic       e_int;
        logic       e_svc;
        logic [1:0] e_id;
        logic [7:0] e_vec;
        logic [3:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic [3:0] irq, input logic mw, input logic [3:0] md,
                       input logic ack, input logic ret, input logic e_int, input logic e_svc,
                       input logic [1:0] e_id, input logic [7:0] e_vec,
                       input logic [3:0] e_pend);
        vec_t v;
        v.irq = irq; v.mw = mw; v.md = md; v.ack = ack; v.ret = ret;
        v.e_int = e_int; v.e_svc = e_svc; v.e_id = e_id; v.e_vec = e_vec; v.e_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] wvec;

        reset     = 1'b0;
        irq_in    = '0;
        mask_wr   = 1'b0;
        mask_data = '0;
        int_ack   = 1'b0;
        int_ret   = 1'b0;

        //  irq     mw  md      ack ret  int svc id  vec     pend
        // single request on source 2
        row(4'b0000, 1, 4'b1111, 0, 0,   0, 0, 0, 8'hE0, 4'b0000);
        row(4'b0100, 0, 4'b0000, 0, 0,   0, 0, 0, 8'hE0, 4'b0100);
        row(4'b0100, 0, 4'b0000, 0, 0,   1, 0, 2, 8'hE8, 4'b0100);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 2, 8'hE8, 4'b0000);
        row(4'b0000, 0, 4'b0000, 0, 0,   0, 1, 2, 8'hE8, 4'b0000);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 2, 8'hE8, 4'b0000);
        // priority: sources 3 and 1 together
        row(4'b1010, 0, 4'b0000, 0, 0,   0, 0, 2, 8'hE8, 4'b1010);
        row(4'b1010, 0, 4'b0000, 0, 0,   1, 0, 1, 8'hE4, 4'b1010);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 1, 8'hE4, 4'b1000);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 1, 8'hE4, 4'b1000);
        row(4'b0000, 0, 4'b0000, 0, 0,   1, 0, 3, 8'hEC, 4'b1000);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 3, 8'hEC, 4'b0000);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 3, 8'hEC, 4'b0000);
        // masking and withdrawal
        row(4'b0000, 1, 4'b0001, 0, 0,   0, 0, 3, 8'hEC, 4'b0000);
        row(4'b0010, 0, 4'b0000, 0, 0,   0, 0, 3, 8'hEC, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   0, 0, 3, 8'hEC, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   0, 0, 3, 8'hEC, 4'b0010);
        row(4'b0000, 1, 4'b0011, 0, 0,   0, 0, 3, 8'hEC, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   1, 0, 1, 8'hE4, 4'b0010);
        row(4'b0000, 1, 4'b0000, 0, 0,   1, 0, 1, 8'hE4, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   0, 0, 1, 8'hE4, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   0, 0, 1, 8'hE4, 4'b0010);
        // no nesting: source 0 arrives while source 2 is in service
        row(4'b0000, 1, 4'b0101, 0, 0,   0, 0, 1, 8'hE4, 4'b0010);
        row(4'b0100, 0, 4'b0000, 0, 0,   0, 0, 1, 8'hE4, 4'b0110);
        row(4'b0000, 0, 4'b0000, 0, 0,   1, 0, 2, 8'hE8, 4'b0110);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 2, 8'hE8, 4'b0010);
        row(4'b0001, 0, 4'b0000, 0, 0,   0, 1, 2, 8'hE8, 4'b0011);
        row(4'b0000, 0, 4'b0000, 0, 0,   0, 1, 2, 8'hE8, 4'b0011);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 2, 8'hE8, 4'b0011);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 2, 8'hE8, 4'b0011);
        row(4'b0000, 0, 4'b0000, 0, 0,   1, 0, 0, 8'hE0, 4'b0011);
        row(4'b0000, 0, 4'b0000, 0, 1,   1, 0, 0, 8'hE0, 4'b0011);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 0, 8'hE0, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 0, 8'hE0, 4'b0010);
        // set/clear collision on source 1
        row(4'b0000, 1, 4'b0010, 0, 0,   0, 0, 0, 8'hE0, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   1, 0, 1, 8'hE4, 4'b0010);
        row(4'b0010, 0, 4'b0000, 1, 0,   0, 1, 1, 8'hE4, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 1, 8'hE4, 4'b0010);
        row(4'b0000, 0, 4'b0000, 0, 0,   1, 0, 1, 8'hE4, 4'b0010);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 1, 8'hE4, 4'b0000);
        row(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 1, 8'hE4, 4'b0000);
        row(4'b0000, 0, 4'b0000, 1, 0,   0, 0, 1, 8'hE4, 4'b0000);

        // reset state
        #12;
        check("rst interrupt", 32'(interrupt), 32'd0);
        check("rst in_service", 32'(in_service), 32'd0);
        check("rst int_id", 32'(int_id), 32'd0);
        check("rst int_vector", 32'(int_vector), 32'hE0);
        check("rst pending", 32'(pending), 32'd0);
        check("rst wrap int_vector", 32'(int_vector2), 32'hFC);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            irq_in    = vecs[i].irq;
            mask_wr   = vecs[i].mw;
            mask_data = vecs[i].md;
            int_ack   = vecs[i].ack;
            int_ret   = vecs[i].ret;
            tick();
            wvec = 8'hFC + (8'(vecs[i].e_id) << 2);
            check($sformatf("row%0d interrupt", i), 32'(interrupt), 32'(vecs[i].e_int));
            check($sformatf("row%0d in_service", i), 32'(in_service), 32'(vecs[i].e_svc));
            check($sformatf("row%0d int_id", i), 32'(int_id), 32'(vecs[i].e_id));
            check($sformatf("row%0d int_vector", i), 32'(int_vector), 32'(vecs[i].e_vec));
            check($sformatf("row%0d pending", i), 32'(pending), 32'(vecs[i].e_pend));
            check($sformatf("row%0d wrap int_vector", i), 32'(int_vector2), 32'(wvec));
        end
        irq_in  = '0;
        mask_wr = 1'b0;
        int_ack = 1'b0;
        int_ret = 1'b0;

        // asynchronous reset in the middle of a service window (mask is 4'b0010 here)
        irq_in = 4'b0011;
        tick();
        check("ar pending set", 32'(pending), 32'b0011);
        irq_in = 4'b0000;
        tick();
        check("ar interrupt", 32'(interrupt), 32'd1);
        check("ar int_id", 32'(int_id), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ar in_service", 32'(in_service), 32'd1);
        check("ar pending left", 32'(pending), 32'b0001);
        #3;
        reset = 1'b0;
        #1;
        check("ar async in_service", 32'(in_service), 32'd0);
        check("ar async interrupt", 32'(interrupt), 32'd0);
        check("ar async pending", 32'(pending), 32'd0);
        check("ar async int_vector", 32'(int_vector), 32'hE0);
        check("ar async int_id", 32'(int_id), 32'd0);
        check("ar async wrap vector", 32'(int_vector2), 32'hFC);
        tick();
        #3;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ar idle%0d interrupt", i), 32'(interrupt), 32'd0);
            check($sformatf("ar idle%0d in_service", i), 32'(in_service), 32'd0);
            check($sformatf("ar idle%0d pending", i), 32'(pending), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
